multicycle_ctrl: RTL and testbench

Parametrised successor to the multicycle processor control FSM. It sequences fetch, decode and execute for the 4-bit-opcode ISA and drives the datapath load/select/ALU controls. Over the first generation it adds a variable-latency memory handshake, explicit HALT and ILLEGAL terminal states, a merged conditional-branch state, and a retired-instruction counter. It sits between the instruction register and the datapath, in place of the first-generation controller.

---
 rtl/ctrl_pkg.sv | 76 +++++++
 rtl/retire_counter.sv | 23 ++
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and encodings for the multicycle controller
// Purpose : state enum, opcode constants, ALU encodings and the decode
//           helper used by multicycle_ctrl.
// Ports   : none (package).
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET   = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_ASN     = 4'd3,
      S_SHIFT   = 4'd4,
      S_ALU_WB  = 4'd5,
      S_ORI_RD  = 4'd6,
      S_ORI_EX  = 4'd7,
      S_ORI_WB  = 4'd8,
      S_LD_MEM  = 4'd9,
      S_LD_WB   = 4'd10,
      S_ST_MEM  = 4'd11,
      S_BR      = 4'd12,
      S_HALT    = 4'd13,
      S_ILLEGAL = 4'd14
   } state_t;

   // Full 4-bit opcodes
   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_HALT  = 4'b0001;
   localparam logic [3:0] OP_STORE = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0100;
   localparam logic [3:0] OP_BZ    = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_NAND  = 4'b1000;
   localparam logic [3:0] OP_BNZ   = 4'b1001;
   localparam logic [3:0] OP_BPZ   = 4'b1101;

   // Shift and ori are identified by their low three bits only
   localparam logic [2:0] OP_SHIFT_LO = 3'b011;
   localparam logic [2:0] OP_ORI_LO   = 3'b111;

   // ALU operation
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_OR    = 3'b010;
   localparam logic [2:0] ALUOP_NAND  = 3'b011;
   localparam logic [2:0] ALUOP_SHIFT = 3'b100;

   // ALU B-source select
   localparam logic [2:0] ALU2_REG   = 3'b000;
   localparam logic [2:0] ALU2_ONE   = 3'b001;
   localparam logic [2:0] ALU2_BROFS = 3'b010;
   localparam logic [2:0] ALU2_ORIMM = 3'b011;
   localparam logic [2:0] ALU2_SHAMT = 3'b100;

   // State following DECODE for a given opcode; unknown opcodes trap.
   function automatic state_t decode_next(input logic [3:0] op);
      state_t nxt;
      if (op == OP_ADD || op == OP_SUB || op == OP_NAND)
         nxt = S_ASN;
      else if (op[2:0] == OP_SHIFT_LO)
         nxt = S_SHIFT;
      else if (op[2:0] == OP_ORI_LO)
         nxt = S_ORI_RD;
      else if (op == OP_LOAD)
         nxt = S_LD_MEM;
      else if (op == OP_STORE)
         nxt = S_ST_MEM;
      else if (op == OP_BPZ || op == OP_BZ || op == OP_BNZ)
         nxt = S_BR;
      else if (op == OP_HALT)
         nxt = S_HALT;
      else
         nxt = S_ILLEGAL;
      return nxt;
   endfunction

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - enable counter for retired instructions
// Purpose : CNT_W-bit counter, +1 per enabled edge, wraps silently.
// Ports   : clock  - rising-edge clock
//           reset  - asynchronous active-low clear
//           en     - count on this edge
//           count  - current count
module retire_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (en)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle processor control FSM with memory handshake
// Purpose : sequences fetch/decode/execute for the 4-bit-opcode ISA and
//           drives datapath controls; counts retired instructions.
// Ports   : clock, reset (async active-low)
//           instr[3:0], N, Z, mem_ready        - inputs
//           PCwrite .. FlagWrite, ALU2, ALUop  - datapath controls
//           halted, illegal                    - terminal-state status
//           instr_count[CNT_W-1:0]             - retired-instruction count
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter int CNT_W         = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       instr,
   input  logic             N,
   input  logic             Z,
   input  logic             mem_ready,
   output logic             PCwrite,
   output logic             AddrSel,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRload,
   output logic             R1Sel,
   output logic             MDRload,
   output logic             R1R2Load,
   output logic             ALU1,
   output logic             ALUOutWrite,
   output logic             RFWrite,
   output logic             RegIn,
   output logic             FlagWrite,
   output logic [2:0]       ALU2,
   output logic [2:0]       ALUop,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   state_t state;
   state_t state_nxt;
   logic   ready;
   logic   retire;

   // Without the handshake every memory access completes in one cycle.
   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= S_RESET;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      retire      = 1'b0;
      PCwrite     = 1'b0;
      AddrSel     = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRload      = 1'b0;
      R1Sel       = 1'b0;
      MDRload     = 1'b0;
      R1R2Load    = 1'b0;
      ALU1        = 1'b0;
      ALUOutWrite = 1'b0;
      RFWrite     = 1'b0;
      RegIn       = 1'b0;
      FlagWrite   = 1'b0;
      ALU2        = ALU2_REG;
      ALUop       = ALUOP_ADD;
      halted      = 1'b0;
      illegal     = 1'b0;

      case (state)
         S_RESET: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            // PC+1 computed while IR loads; both commit only on the ready cycle
            AddrSel = 1'b1;
            MemRead = 1'b1;
            ALU2    = ALU2_ONE;
            ALUop   = ALUOP_ADD;
            IRload  = ready;
            PCwrite = ready;
            if (ready)
               state_nxt = S_DECODE;
         end
         S_DECODE: begin
            R1R2Load  = 1'b1;
            state_nxt = decode_next(instr);
         end
         S_ASN: begin
            ALU1        = 1'b1;
            ALU2        = ALU2_REG;
            ALUOutWrite = 1'b1;
            FlagWrite   = 1'b1;
            case (instr)
               OP_SUB:  ALUop = ALUOP_SUB;
               OP_NAND: ALUop = ALUOP_NAND;
               default: ALUop = ALUOP_ADD;
            endcase
            state_nxt = S_ALU_WB;
         end
         S_SHIFT: begin
            ALU1        = 1'b1;
            ALU2        = ALU2_SHAMT;
            ALUop       = ALUOP_SHIFT;
            ALUOutWrite = 1'b1;
            FlagWrite   = 1'b1;
            state_nxt   = S_ALU_WB;
         end
         S_ALU_WB: begin
            RFWrite   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_ORI_RD: begin
            // ori uses the fixed accumulator register, selected via R1Sel
            R1Sel     = 1'b1;
            R1R2Load  = 1'b1;
            state_nxt = S_ORI_EX;
         end
         S_ORI_EX: begin
            ALU1        = 1'b1;
            ALU2        = ALU2_ORIMM;
            ALUop       = ALUOP_OR;
            ALUOutWrite = 1'b1;
            FlagWrite   = 1'b1;
            state_nxt   = S_ORI_WB;
         end
         S_ORI_WB: begin
            R1Sel     = 1'b1;
            RFWrite   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_LD_MEM: begin
            MemRead = 1'b1;
            MDRload = ready;
            if (ready)
               state_nxt = S_LD_WB;
         end
         S_LD_WB: begin
            ALUOutWrite = 1'b1;
            RFWrite     = 1'b1;
            RegIn       = 1'b1;
            retire      = 1'b1;
            state_nxt   = S_FETCH;
         end
         S_ST_MEM: begin
            MemWrite = 1'b1;
            if (ready) begin
               retire    = 1'b1;
               state_nxt = S_FETCH;
            end
         end
         S_BR: begin
            ALU2  = ALU2_BROFS;
            ALUop = ALUOP_ADD;
            case (instr)
               OP_BPZ:  PCwrite = ~N;
               OP_BZ:   PCwrite = Z;
               OP_BNZ:  PCwrite = ~Z;
               default: PCwrite = 1'b0;
            endcase
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
         end
         default: begin
            state_nxt = S_RESET;
         end
      endcase
   end

   retire_counter #(
      .CNT_W (CNT_W)
   ) u_retire_counter (
      .clock (clock),
      .reset (reset),
      .en    (retire),
      .count (instr_count)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic        clock = 1'b0;
   logic        reset, reset2;
   logic [3:0]  instr, instr2;
   logic        N, Z, mem_ready, mem_ready2;

   logic        PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload;
   logic        R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite;
   logic [2:0]  ALU2, ALUop;
   logic        halted, illegal;
   logic [15:0] instr_count;

   logic        PCwrite2, AddrSel2, MemRead2, MemWrite2, IRload2, R1Sel2, MDRload2;
   logic        R1R2Load2, ALU1_2, ALUOutWrite2, RFWrite2, RegIn2, FlagWrite2;
   logic [2:0]  ALU2_2, ALUop2;
   logic        halted2, illegal2;
   logic [1:0]  instr_count2;

   logic [18:0] ctrl, ctrl2;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [18:0] C_PC  = 19'h40000, C_AD  = 19'h20000, C_MR  = 19'h10000;
   localparam logic [18:0] C_MW  = 19'h08000, C_IR  = 19'h04000, C_R1S = 19'h02000;
   localparam logic [18:0] C_MDR = 19'h01000, C_R12 = 19'h00800, C_A1  = 19'h00400;
   localparam logic [18:0] C_AOW = 19'h00200, C_RFW = 19'h00100, C_RIN = 19'h00080;
   localparam logic [18:0] C_FW  = 19'h00040;

   localparam logic [18:0] E_F_RDY  = C_PC | C_AD | C_MR | C_IR | 19'h08;
   localparam logic [18:0] E_F_WAIT = C_AD | C_MR | 19'h08;
   localparam logic [18:0] E_DEC    = C_R12;
   localparam logic [18:0] E_ASN    = C_A1 | C_AOW | C_FW;
   localparam logic [18:0] E_SHIFT  = C_A1 | C_AOW | C_FW | 19'h20 | 19'h4;
   localparam logic [18:0] E_WB     = C_RFW;
   localparam logic [18:0] E_ORI_RD = C_R1S | C_R12;
   localparam logic [18:0] E_ORI_EX = C_A1 | C_AOW | C_FW | 19'h18 | 19'h2;
   localparam logic [18:0] E_ORI_WB = C_R1S | C_RFW;
   localparam logic [18:0] E_BR     = 19'h10;
   localparam logic [18:0] E_LD_WB  = C_AOW | C_RFW | C_RIN;

   multicycle_ctrl #(.MEM_HANDSHAKE(1'b1), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .instr(instr), .N(N), .Z(Z), .mem_ready(mem_ready),
      .PCwrite(PCwrite), .AddrSel(AddrSel), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRload(IRload), .R1Sel(R1Sel), .MDRload(MDRload), .R1R2Load(R1R2Load),
      .ALU1(ALU1), .ALUOutWrite(ALUOutWrite), .RFWrite(RFWrite), .RegIn(RegIn),
      .FlagWrite(FlagWrite), .ALU2(ALU2), .ALUop(ALUop), .halted(halted),
      .illegal(illegal), .instr_count(instr_count));

   multicycle_ctrl #(.MEM_HANDSHAKE(1'b0), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset2), .instr(instr2), .N(1'b0), .Z(1'b0), .mem_ready(mem_ready2),
      .PCwrite(PCwrite2), .AddrSel(AddrSel2), .MemRead(MemRead2), .MemWrite(MemWrite2),
      .IRload(IRload2), .R1Sel(R1Sel2), .MDRload(MDRload2), .R1R2Load(R1R2Load2),
      .ALU1(ALU1_2), .ALUOutWrite(ALUOutWrite2), .RFWrite(RFWrite2), .RegIn(RegIn2),
      .FlagWrite(FlagWrite2), .ALU2(ALU2_2), .ALUop(ALUop2), .halted(halted2),
      .illegal(illegal2), .instr_count(instr_count2));

   assign ctrl  = {PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load,
                   ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite, ALU2, ALUop};
   assign ctrl2 = {PCwrite2, AddrSel2, MemRead2, MemWrite2, IRload2, R1Sel2, MDRload2, R1R2Load2,
                   ALU1_2, ALUOutWrite2, RFWrite2, RegIn2, FlagWrite2, ALU2_2, ALUop2};

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change at posedge+2; outputs are sampled at posedge+3.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic cyc(input string tag, input logic [18:0] ec, input int ecnt);
      #1;
      chk({tag, "_ctl"}, 32'(ctrl), 32'(ec));
      chk({tag, "_cnt"}, 32'(instr_count), 32'(ecnt));
   endtask

   initial begin
      reset = 1'b0; reset2 = 1'b0;
      instr = 4'b0000; instr2 = 4'b0010;
      N = 1'b0; Z = 1'b0; mem_ready = 1'b1; mem_ready2 = 1'b0;

      #3;
      chk("rst_ctl", 32'(ctrl), 32'h0);
      chk("rst_cnt", 32'(instr_count), 32'h0);
      chk("rst_status", 32'({halted, illegal}), 32'h0);
      tick(); tick();
      reset = 1'b1;
      cyc("rst_state", 19'h0, 0);

      // add with zero wait states
      tick(); instr = 4'b0100; cyc("add_fetch", E_F_RDY, 0);
      tick(); cyc("add_dec", E_DEC, 0);
      tick(); cyc("add_asn", E_ASN, 0);
      tick(); mem_ready = 1'b0; cyc("add_wb", E_WB, 0);

      // fetch with three wait states, then bz with Z=0
      tick(); instr = 4'b0101; cyc("wait1", E_F_WAIT, 1);
      tick(); cyc("wait2", E_F_WAIT, 1);
      tick(); cyc("wait3", E_F_WAIT, 1);
      tick(); mem_ready = 1'b1; cyc("wait4", E_F_RDY, 1);
      tick(); cyc("bz0_dec", E_DEC, 1);
      tick(); cyc("bz0_br", E_BR, 1);

      // bz with Z=1
      tick(); Z = 1'b1; cyc("bz1_fetch", E_F_RDY, 2);
      tick(); cyc("bz1_dec", E_DEC, 2);
      tick(); cyc("bz1_br", E_BR | C_PC, 2);

      // ori: 5 cycles
      tick(); instr = 4'b0111; cyc("ori_fetch", E_F_RDY, 3);
      tick(); cyc("ori_dec", E_DEC, 3);
      tick(); cyc("ori_rd", E_ORI_RD, 3);
      tick(); cyc("ori_ex", E_ORI_EX, 3);
      tick(); cyc("ori_wb", E_ORI_WB, 3);

      // shift (1011)
      tick(); instr = 4'b1011; cyc("sh_fetch", E_F_RDY, 4);
      tick(); cyc("sh_dec", E_DEC, 4);
      tick(); cyc("sh_ex", E_SHIFT, 4);
      tick(); cyc("sh_wb", E_WB, 4);

      // load with one wait state
      tick(); instr = 4'b0000; cyc("ld_fetch", E_F_RDY, 5);
      tick(); mem_ready = 1'b0; cyc("ld_dec", E_DEC, 5);
      tick(); cyc("ld_wait", C_MR, 5);
      tick(); mem_ready = 1'b1; cyc("ld_mem", C_MR | C_MDR, 5);
      tick(); cyc("ld_wb", E_LD_WB, 5);

      // store, zero wait
      tick(); instr = 4'b0010; cyc("st_fetch", E_F_RDY, 6);
      tick(); cyc("st_dec", E_DEC, 6);
      tick(); cyc("st_mem", C_MW, 6);

      // sub
      tick(); instr = 4'b0110; cyc("sub_fetch", E_F_RDY, 7);
      tick(); cyc("sub_dec", E_DEC, 7);
      tick(); cyc("sub_asn", E_ASN | 19'h1, 7);
      tick(); cyc("sub_wb", E_WB, 7);

      // bnz with Z=0 (taken), bpz with N=1 (not taken)
      tick(); instr = 4'b1001; Z = 1'b0; cyc("bnz_fetch", E_F_RDY, 8);
      tick(); cyc("bnz_dec", E_DEC, 8);
      tick(); cyc("bnz_br", E_BR | C_PC, 8);
      tick(); instr = 4'b1101; N = 1'b1; cyc("bpz_fetch", E_F_RDY, 9);
      tick(); cyc("bpz_dec", E_DEC, 9);
      tick(); cyc("bpz_br", E_BR, 9);

      // illegal opcode 1010 is absorbing and does not retire
      tick(); instr = 4'b1010; cyc("ill_fetch", E_F_RDY, 10);
      tick(); cyc("ill_dec", E_DEC, 10);
      tick(); cyc("ill_a", 19'h0, 10);
      chk("ill_status_a", 32'({halted, illegal}), 32'h1);
      tick(); mem_ready = 1'b0; cyc("ill_b", 19'h0, 10);
      chk("ill_status_b", 32'({halted, illegal}), 32'h1);

      // async reset clears status and count without a clock edge
      reset = 1'b0; mem_ready = 1'b1;
      cyc("ill_rst", 19'h0, 0);
      chk("ill_rst_status", 32'({halted, illegal}), 32'h0);

      // halt
      tick(); reset = 1'b1; cyc("h_rst", 19'h0, 0);
      tick(); instr = 4'b0001; cyc("h_fetch", E_F_RDY, 0);
      tick(); cyc("h_dec", E_DEC, 0);
      tick(); cyc("h_a", 19'h0, 0);
      chk("h_status_a", 32'({halted, illegal}), 32'h2);
      tick(); cyc("h_b", 19'h0, 0);
      chk("h_status_b", 32'({halted, illegal}), 32'h2);

      // reset mid-store with mem_ready low
      reset = 1'b0;
      tick(); reset = 1'b1; cyc("m_rst", 19'h0, 0);
      tick(); instr = 4'b0100; cyc("m_add_fetch", E_F_RDY, 0);
      tick(); cyc("m_add_dec", E_DEC, 0);
      tick(); cyc("m_add_asn", E_ASN, 0);
      tick(); cyc("m_add_wb", E_WB, 0);
      tick(); instr = 4'b0010; cyc("m_st_fetch", E_F_RDY, 1);
      tick(); mem_ready = 1'b0; cyc("m_st_dec", E_DEC, 1);
      tick(); cyc("m_st_mem", C_MW, 1);
      reset = 1'b0;
      cyc("m_st_rst", 19'h0, 0);
      tick(); reset = 1'b1; mem_ready = 1'b1; cyc("m_after_rst", 19'h0, 0);
      tick(); cyc("m_after_fetch", E_F_RDY, 0);

      // no-handshake instance: stores complete in 3 cycles; 2-bit count wraps
      reset2 = 1'b1;
      #1;
      chk("nh_rst", 32'(ctrl2), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         chk($sformatf("nh_fetch%0d", i), 32'(ctrl2), 32'(E_F_RDY));
         chk($sformatf("nh_cnt%0d", i), 32'(instr_count2), 32'(i % 4));
         tick(); #1;
         chk($sformatf("nh_dec%0d", i), 32'(ctrl2), 32'(E_DEC));
         tick(); #1;
         chk($sformatf("nh_st%0d", i), 32'(ctrl2), 32'(C_MW));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
